// File: rtl/trap_controller.sv
// Machine-mode trap controller: takes interrupts, exceptions and mret, updates trap CSRs and redirects fetch.
// Trap CSRs and redirect appear 2 cycles after acceptance (mret: 1); redirect is held until redirect_ready_i.
module trap_controller #(
  parameter int              MLEN        = 64,
  parameter logic [MLEN-1:0] RESET_MTVEC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            exc_valid_i,
  output logic            exc_ready_o,
  input  logic [5:0]      exc_code_i,
  input  logic [MLEN-1:0] exc_pc_i,
  input  logic [MLEN-1:0] exc_tval_i,
  input  logic [MLEN-1:0] next_pc_i,
  input  logic [MLEN-1:0] irq_i,
  input  logic [MLEN-1:0] mie_i,
  input  logic            mret_i,
  input  logic            csr_we_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [MLEN-1:0] csr_wdata_i,
  output logic            redirect_valid_o,
  input  logic            redirect_ready_i,
  output logic [MLEN-1:0] redirect_pc_o,
  output logic [MLEN-1:0] mstatus_o,
  output logic [MLEN-1:0] mepc_o,
  output logic [MLEN-1:0] mcause_o,
  output logic [MLEN-1:0] mtval_o,
  output logic [MLEN-1:0] mtvec_o,
  output logic [1:0]      priv_o
);

  localparam logic [1:0]      PRIV_U   = 2'b00;
  localparam logic [1:0]      PRIV_M   = 2'b11;
  // Machine/supervisor software, timer and external lines plus bit 13.
  localparam logic [MLEN-1:0] IRQ_MASK = MLEN'(14'h2aaa);

  typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT} state_t;

  typedef struct packed {
    logic            intr;
    logic [5:0]      code;
    logic [MLEN-1:0] epc;
    logic [MLEN-1:0] tval;
  } trap_t;

  state_t          state_q, state_d;
  trap_t           trap_q;
  logic [1:0]      priv_q, mpp_q;
  logic            mie_q, mpie_q;
  logic [MLEN-1:0] mepc_q, mcause_q, mtval_q, mtvec_q;
  logic            redirect_valid_q;
  logic [MLEN-1:0] redirect_pc_q;

  logic [MLEN-1:0] irq_pend;
  logic            irq_en;
  logic [5:0]      irq_code;
  logic            take_irq, take_exc, take_mret;
  logic [MLEN-1:0] tvec_base, trap_pc;

  assign irq_pend = irq_i & mie_i & IRQ_MASK;
  assign irq_en   = (priv_q != PRIV_M) || mie_q;

  always_comb begin
    irq_code = 6'd13;
    if      (irq_pend[11]) irq_code = 6'd11;
    else if (irq_pend[3])  irq_code = 6'd3;
    else if (irq_pend[7])  irq_code = 6'd7;
    else if (irq_pend[9])  irq_code = 6'd9;
    else if (irq_pend[1])  irq_code = 6'd1;
    else if (irq_pend[5])  irq_code = 6'd5;
  end

  always_comb begin
    state_d     = state_q;
    take_irq    = 1'b0;
    take_exc    = 1'b0;
    take_mret   = 1'b0;
    exc_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        take_irq    = irq_en && (|irq_pend);
        exc_ready_o = !take_irq;
        take_exc    = !take_irq && exc_valid_i;
        take_mret   = !take_irq && !exc_valid_i && mret_i;
        if (take_irq || take_exc) state_d = COMMIT;
        else if (take_mret)       state_d = REDIRECT;
      end
      COMMIT:   state_d = REDIRECT;
      REDIRECT: if (redirect_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Vectored mode only applies to interrupts; modes 2 and 3 behave as direct.
  assign tvec_base = {mtvec_q[MLEN-1:2], 2'b00};
  assign trap_pc   = (mtvec_q[1:0] == 2'b01 && trap_q.intr)
                   ? tvec_base + MLEN'({trap_q.code, 2'b00}) : tvec_base;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trap_q           <= '0;
      priv_q           <= PRIV_M;
      mpp_q            <= PRIV_U;
      mie_q            <= 1'b0;
      mpie_q           <= 1'b0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
      mtvec_q          <= RESET_MTVEC;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      // Software writes first so trap/mret updates below override them.
      if (csr_we_i) begin
        case (csr_addr_i)
          12'h300: begin
            mie_q  <= csr_wdata_i[3];
            mpie_q <= csr_wdata_i[7];
            if (csr_wdata_i[12:11] != 2'b10) mpp_q <= csr_wdata_i[12:11];
          end
          12'h305: mtvec_q  <= csr_wdata_i;
          12'h341: mepc_q   <= csr_wdata_i & ~MLEN'(1);
          12'h342: mcause_q <= csr_wdata_i;
          12'h343: mtval_q  <= csr_wdata_i;
          default: ;
        endcase
      end

      if (take_irq) begin
        trap_q.intr <= 1'b1;
        trap_q.code <= irq_code;
        trap_q.epc  <= next_pc_i;
        trap_q.tval <= '0;
      end else if (take_exc) begin
        trap_q.intr <= 1'b0;
        trap_q.code <= exc_code_i;
        trap_q.epc  <= exc_pc_i;
        trap_q.tval <= exc_tval_i;
      end

      case (state_q)
        IDLE: if (take_mret) begin
          mie_q            <= mpie_q;
          mpie_q           <= 1'b1;
          priv_q           <= mpp_q;
          mpp_q            <= PRIV_U;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= mepc_q;
        end
        COMMIT: begin
          mepc_q           <= trap_q.epc & ~MLEN'(1);
          mcause_q         <= {trap_q.intr, {(MLEN-7){1'b0}}, trap_q.code};
          mtval_q          <= trap_q.tval;
          mpie_q           <= mie_q;
          mie_q            <= 1'b0;
          mpp_q            <= priv_q;
          priv_q           <= PRIV_M;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= trap_pc;
        end
        REDIRECT: if (redirect_ready_i) redirect_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    mstatus_o        = '0;
    mstatus_o[3]     = mie_q;
    mstatus_o[7]     = mpie_q;
    mstatus_o[12:11] = mpp_q;
  end

  assign mepc_o           = mepc_q;
  assign mcause_o         = mcause_q;
  assign mtval_o          = mtval_q;
  assign mtvec_o          = mtvec_q;
  assign priv_o           = priv_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;

endmodule

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 SHALL have parameter MLEN, default 64: CSR/PC width.
REQ-002 SHALL have parameter RESET_MTVEC, default 64'h0: mtvec value at reset.
REQ-003 SHALL have port clk_i  in  1: sole clock, rising edge.
REQ-004 SHALL have port rst_i  in  1: asynchronous, active-high reset.
REQ-005 SHALL have port exc_valid_i  in  1: synchronous exception request from commit.
REQ-006 SHALL have port exc_ready_o  out  1: exception accepted this cycle when high with exc_valid_i.
REQ-007 SHALL have port exc_code_i  in  6: synchronous exception code (0..19 encoding).
REQ-008 SHALL have ports exc_pc_i and exc_tval_i  in  MLEN: faulting PC and trap value.
REQ-009 SHALL have port next_pc_i  in  MLEN: resume PC used as mepc for interrupts.
REQ-010 SHALL have ports irq_i and mie_i  in  MLEN: pending interrupt lines (mip layout) and enable mask.
REQ-011 SHALL have port mret_i  in  1: mret committed.
REQ-012 SHALL have ports csr_we_i 1, csr_addr_i 12, csr_wdata_i MLEN  in: software CSR write.
REQ-013 SHALL have ports redirect_valid_o out 1, redirect_ready_i in 1, redirect_pc_o out MLEN: fetch redirect handshake.
REQ-014 SHALL have outputs mstatus_o, mepc_o, mcause_o, mtval_o, mtvec_o  MLEN and priv_o 2.

Function
REQ-015 SHALL implement FSM IDLE, COMMIT, REDIRECT; exc_ready_o high only in IDLE with no interrupt taken.
REQ-016 SHALL take an interrupt in IDLE when (irq_i & mie_i) has any of bits 1,3,5,7,9,11,13 set and (priv_o != MACHINE or mstatus.MIE=1); other bits ignored.
REQ-017 SHALL select interrupt priority 11 > 3 > 7 > 9 > 1 > 5 > 13.
REQ-018 SHALL prioritise: interrupt > exc_valid_i > mret_i; losers are not consumed (mret_i ignored that cycle).
REQ-019 SHALL, on trap acceptance (IDLE edge), capture cause, interrupt flag, epc (exc_pc_i or next_pc_i), tval (exc_tval_i or 0), move to COMMIT.
REQ-020 SHALL in COMMIT edge write mepc=epc with bit0 cleared, mcause={interrupt, code zero-extended}, mtval=tval, MPIE=MIE, MIE=0, MPP=priv, priv=MACHINE; move to REDIRECT.
REQ-021 SHALL compute trap redirect_pc_o: base={mtvec[MLEN-1:2],2'b00}; if mtvec[1:0]=1 and interrupt, base+4*code; mtvec[1:0]>=2 treated as direct.
REQ-022 SHALL on accepted mret in IDLE set MIE=MPIE, MPIE=1, priv=MPP, MPP=USER, redirect_pc_o=mepc (pre-update value), move directly to REDIRECT.
REQ-023 SHALL hold redirect_valid_o high and redirect_pc_o stable in REDIRECT until redirect_ready_i; return to IDLE on that edge.
REQ-024 SHALL latency: trap accepted cycle N -> CSRs visible N+2, redirect_valid_o high from N+2; mret N -> redirect_valid_o high N+1.
REQ-025 SHALL accept CSR writes in any state: 0x300 writes only MIE(3), MPIE(7), MPP(12:11), MPP=2'b10 ignored (keeps old); 0x305 mtvec; 0x341 mepc (bit0 forced 0); 0x342 mcause; 0x343 mtval; other addresses ignored.
REQ-026 SHALL give COMMIT/mret updates priority over a same-cycle CSR write to the same register/field.
REQ-027 SHALL drive all unimplemented mstatus_o bits as 0.

Reset
REQ-028 SHALL on rst_i asynchronously set state IDLE, priv_o=MACHINE, mstatus/mepc/mcause/mtval=0, mtvec=RESET_MTVEC, redirect_valid_o=0, redirect_pc_o=0.
REQ-029 SHALL abort any in-flight trap or redirect when reset asserts mid-operation; no CSR update survives.

Verification
REQ-030 SHALL cover: priv=U, exc_valid_i, code 2, pc 0x1000, tval 0xDEAD, mtvec 0x8000 -> N+2: mepc 0x1000, mcause 2, mtval 0xDEAD, MPP=00, priv=11, redirect 0x8000.
REQ-031 SHALL cover: mtvec 0x8001, MIE=1, irq_i=mie_i=bits 7|11 -> mcause MSB=1 code 11, mtval 0, redirect 0x802C, mepc=next_pc_i.
REQ-032 SHALL cover: same-cycle interrupt and exc_valid_i -> exc_ready_o=0, interrupt taken; exception accepted after redirect completes.
REQ-033 SHALL cover: mret with MPP=01, MPIE=1, mepc 0x2000 -> priv=01, MIE=1, MPIE=1, MPP=00, redirect 0x2000 at N+1.
REQ-034 SHALL cover: redirect_ready_i low 5 cycles -> redirect_valid_o and redirect_pc_o stable; rst_i pulse in REDIRECT -> valid drops immediately, CSRs at reset values.
REQ-035 SHALL cover: CSR write 0x300 MPP=2'b10 -> MPP unchanged; CSR write to mepc during COMMIT -> trap epc wins.
